// File: rtl/knn_feeder_pkg.sv
// Shared types and constants for the kNN training-sample feeder.
// Label 0 (BUBBLE) marks a cycle that carries no training sample.
package knn_feeder_pkg;

    localparam int NUM_BIT   = 32;
    localparam int LABEL_W   = 2;
    localparam int INDEX_W   = 8;
    localparam int MEM_DEPTH = 1 << INDEX_W;

    localparam logic [LABEL_W-1:0] BUBBLE = 2'd0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_OUT    = 3'd4
    } state_t;

    typedef struct packed {
        logic [LABEL_W-1:0] label;
        logic [NUM_BIT-1:0] data;
    } sample_t;

endpackage

// File: rtl/knn_feeder_if.sv
// Bus between the feeder and its environment: training writes, test-vector
// handshake, sample stream to the kNN pipeline and the classification result.
interface knn_feeder_if;
    import knn_feeder_pkg::*;

    logic                wr_en;
    logic [INDEX_W-1:0]  wr_addr;
    logic [NUM_BIT-1:0]  wr_data;
    logic [LABEL_W-1:0]  wr_label;
    logic [INDEX_W-1:0]  num_train;

    logic                test_vld;
    logic                test_rdy;
    logic [NUM_BIT-1:0]  test_in;

    logic [NUM_BIT-1:0]  train_data;
    logic [NUM_BIT-1:0]  test_data;
    logic [LABEL_W-1:0]  label;
    logic [INDEX_W-1:0]  index;
    logic                knn_clr;

    logic [LABEL_W-1:0]  knn_res;
    logic                knn_res_vld;

    logic                out_vld;
    logic                out_rdy;
    logic [LABEL_W-1:0]  out_res;
    logic                out_err;

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_label, num_train,
        input  test_vld, test_in, knn_res, knn_res_vld, out_rdy,
        output test_rdy, train_data, test_data, label, index, knn_clr,
        output out_vld, out_res, out_err
    );

    modport master (
        output wr_en, wr_addr, wr_data, wr_label, num_train,
        output test_vld, test_in, knn_res, knn_res_vld, out_rdy,
        input  test_rdy, train_data, test_data, label, index, knn_clr,
        input  out_vld, out_res, out_err
    );

endinterface

// File: rtl/knn_train_mem.sv
// Training-sample store: one synchronous write port, one asynchronous read
// port. Contents are deliberately not reset.
module knn_train_mem
    import knn_feeder_pkg::*;
(
    input  logic               clk,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_addr,
    input  sample_t            wr_word,
    input  logic [INDEX_W-1:0] rd_addr,
    output sample_t            rd_word
);

    sample_t mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_word;
        end
    end

    assign rd_word = mem[rd_addr];

endmodule

// File: rtl/knn_feeder.sv
// Streams stored training samples alongside a latched test vector into a kNN
// pipeline and returns its classification, with a drain timeout.
//   state  | meaning
//   IDLE   | accept training writes and the next test vector
//   CLEAR  | one-cycle knn_clr pulse to the pipeline
//   STREAM | present mem[0..count-1], one sample per cycle
//   DRAIN  | wait for knn_res_vld, bounded by DRAIN_MAX cycles
//   OUT    | hold the result until the consumer takes it
module knn_feeder
    import knn_feeder_pkg::*;
#(
    parameter int DRAIN_MAX = 32
) (
    input  logic clk,
    input  logic rst,
    knn_feeder_if.slave bus
);

    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_MAX - 1);

    state_t             state;
    logic [INDEX_W-1:0] count;
    logic [INDEX_W-1:0] rd_ptr;
    logic [7:0]         drain_cnt;

    logic               test_rdy_q;
    logic               knn_clr_q;
    logic [NUM_BIT-1:0] train_data_q;
    logic [NUM_BIT-1:0] test_data_q;
    logic [LABEL_W-1:0] label_q;
    logic [INDEX_W-1:0] index_q;
    logic               out_vld_q;
    logic [LABEL_W-1:0] out_res_q;
    logic               out_err_q;

    logic               accept;
    logic               mem_we;
    sample_t            wr_word;
    sample_t            rd_word;

    assign accept  = (state == ST_IDLE) && bus.test_vld && test_rdy_q;
    assign mem_we  = (state == ST_IDLE) && bus.wr_en;
    assign wr_word = {bus.wr_label, bus.wr_data};

    // rd_ptr is 0 in CLEAR, so a write landing with the accept is already visible.
    knn_train_mem u_mem (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (bus.wr_addr),
        .wr_word (wr_word),
        .rd_addr (rd_ptr),
        .rd_word (rd_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            count        <= '0;
            rd_ptr       <= '0;
            drain_cnt    <= '0;
            test_rdy_q   <= 1'b0;
            knn_clr_q    <= 1'b0;
            train_data_q <= '0;
            test_data_q  <= '0;
            label_q      <= BUBBLE;
            index_q      <= '0;
            out_vld_q    <= 1'b0;
            out_res_q    <= '0;
            out_err_q    <= 1'b0;
        end else begin
            knn_clr_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    test_rdy_q <= 1'b1;
                    if (accept) begin
                        test_rdy_q  <= 1'b0;
                        test_data_q <= bus.test_in;
                        count       <= bus.num_train;
                        rd_ptr      <= '0;
                        knn_clr_q   <= 1'b1;
                        state       <= ST_CLEAR;
                    end
                end
                ST_CLEAR, ST_STREAM: begin
                    if (rd_ptr == count) begin
                        train_data_q <= '0;
                        label_q      <= BUBBLE;
                        index_q      <= '0;
                        drain_cnt    <= '0;
                        if (state == ST_CLEAR) begin
                            out_vld_q <= 1'b1;
                            out_res_q <= '0;
                            out_err_q <= 1'b1;
                            state     <= ST_OUT;
                        end else begin
                            state     <= ST_DRAIN;
                        end
                    end else begin
                        train_data_q <= rd_word.data;
                        label_q      <= rd_word.label;
                        index_q      <= rd_ptr;
                        rd_ptr       <= rd_ptr + 8'd1;
                        state        <= ST_STREAM;
                    end
                end
                ST_DRAIN: begin
                    if (bus.knn_res_vld) begin
                        out_vld_q <= 1'b1;
                        out_res_q <= bus.knn_res;
                        out_err_q <= 1'b0;
                        state     <= ST_OUT;
                    end else if (drain_cnt == DRAIN_LAST) begin
                        out_vld_q <= 1'b1;
                        out_res_q <= '0;
                        out_err_q <= 1'b1;
                        state     <= ST_OUT;
                    end else begin
                        drain_cnt <= drain_cnt + 8'd1;
                    end
                end
                ST_OUT: begin
                    if (bus.out_rdy) begin
                        out_vld_q  <= 1'b0;
                        out_res_q  <= '0;
                        out_err_q  <= 1'b0;
                        test_rdy_q <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.test_rdy   = test_rdy_q;
    assign bus.knn_clr    = knn_clr_q;
    assign bus.train_data = train_data_q;
    assign bus.test_data  = test_data_q;
    assign bus.label      = label_q;
    assign bus.index      = index_q;
    assign bus.out_vld    = out_vld_q;
    assign bus.out_res    = out_res_q;
    assign bus.out_err    = out_err_q;

endmodule

// File: tb/tb_knn_feeder.sv
// Self-checking bench for knn_feeder: per-cycle traces of each transaction are
// compared with a cycle-offset reference model of the stream and result.
module tb_knn_feeder;
    import knn_feeder_pkg::*;

    localparam int DRAIN_MAX = 32;
    localparam int OBS_MAX   = 320;

    logic clk;
    logic rst;
    knn_feeder_if bus();

    knn_feeder #(.DRAIN_MAX(DRAIN_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] ref_data  [256];
    logic [1:0]  ref_label [256];

    // observations of the last transaction, indexed by cycles after acceptance
    logic [1:0]  obs_lbl  [OBS_MAX];
    logic [7:0]  obs_idx  [OBS_MAX];
    logic [31:0] obs_dat  [OBS_MAX];
    logic [31:0] obs_tdat [OBS_MAX];
    logic        obs_clr  [OBS_MAX];
    logic        obs_rdy  [OBS_MAX];
    int          out_off;
    logic [1:0]  got_res;
    logic        got_err;
    int          hold_bad;
    logic        acc_rdy;
    logic        vld_after;
    logic        rdy_after;

    function automatic int exp_out_off(int cnt, int res_at);
        if (cnt == 0) return 2;
        if (res_at >= 0 && res_at < DRAIN_MAX) return cnt + 3 + res_at;
        return cnt + 2 + DRAIN_MAX;
    endfunction

    function automatic bit in_stream(int o, int cnt);
        return (o >= 2) && (o <= cnt + 1);
    endfunction

    function automatic logic [1:0] exp_lbl(int o, int cnt);
        return in_stream(o, cnt) ? ref_label[o-2] : BUBBLE;
    endfunction

    function automatic logic [31:0] exp_dat(int o, int cnt);
        return in_stream(o, cnt) ? ref_data[o-2] : 32'd0;
    endfunction

    function automatic logic [7:0] exp_idx(int o, int cnt);
        return in_stream(o, cnt) ? 8'(o - 2) : 8'd0;
    endfunction

    task automatic drive_idle();
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_label = '0;
        bus.num_train = '0; bus.test_vld = 1'b0; bus.test_in = '0;
        bus.knn_res = '0; bus.knn_res_vld = 1'b0; bus.out_rdy = 1'b0;
    endtask

    task automatic mem_write(input logic [7:0] a, input logic [31:0] d, input logic [1:0] l);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d; bus.wr_label = l;
        @(negedge clk);
        bus.wr_en = 1'b0;
        ref_data[a]  = d;
        ref_label[a] = l;
    endtask

    // Drives one complete transaction from an IDLE negedge and records what the DUT shows.
    // wr_off: -1 no write, 0 write together with the accept, >0 write at that offset.
    task automatic run_txn(input logic [31:0] vec, input int cnt, input int res_at,
                           input logic [1:0] res, input int rdy_wait, input int wr_off,
                           input logic [7:0] wa, input logic [31:0] wd, input logic [1:0] wl);
        int c;
        out_off  = -1;
        hold_bad = 0;
        acc_rdy  = bus.test_rdy;
        bus.test_vld = 1'b1; bus.test_in = vec; bus.num_train = 8'(cnt);
        if (wr_off == 0) begin
            bus.wr_en = 1'b1; bus.wr_addr = wa; bus.wr_data = wd; bus.wr_label = wl;
            ref_data[wa]  = wd;
            ref_label[wa] = wl;
        end
        @(negedge clk);
        bus.wr_en = 1'b0; bus.num_train = 8'($urandom);
        c = 1;
        while (out_off < 0 && c < OBS_MAX) begin
            obs_lbl[c]  = bus.label;    obs_idx[c]  = bus.index;
            obs_dat[c]  = bus.train_data; obs_tdat[c] = bus.test_data;
            obs_clr[c]  = bus.knn_clr;  obs_rdy[c]  = bus.test_rdy;
            if (bus.out_vld === 1'b1) begin
                out_off = c;
            end else begin
                bus.test_vld    = (c >= 2);
                bus.test_in     = $urandom;
                bus.knn_res_vld = 1'b0;
                bus.knn_res     = 2'($urandom);
                bus.wr_en       = (wr_off > 0) && (c == wr_off);
                bus.wr_addr = wa; bus.wr_data = wd; bus.wr_label = wl;
                if (cnt > 0 && c == 2) begin
                    bus.knn_res_vld = 1'b1; bus.knn_res = ~res;
                end
                if (res_at >= 0 && c == cnt + 2 + res_at) begin
                    bus.knn_res_vld = 1'b1; bus.knn_res = res;
                end
                @(negedge clk);
                c++;
            end
        end
        bus.test_vld = 1'b0; bus.knn_res_vld = 1'b0; bus.wr_en = 1'b0;
        vld_after = 1'b1; rdy_after = 1'b0;
        if (out_off < 0) return;
        got_res = bus.out_res;
        got_err = bus.out_err;
        bus.out_rdy = 1'b0;
        repeat (rdy_wait) begin
            @(negedge clk);
            if (bus.out_vld !== 1'b1 || bus.out_res !== got_res || bus.out_err !== got_err ||
                bus.test_rdy !== 1'b0) hold_bad++;
        end
        bus.out_rdy = 1'b1;
        @(negedge clk);
        bus.out_rdy = 1'b0;
        vld_after = bus.out_vld;
        rdy_after = bus.test_rdy;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.test_rdy !== 1'b0)   begin n_bad++; $display("FAIL reset_test_rdy: got %b want 0", bus.test_rdy); end
        n_cmp++; if (bus.knn_clr !== 1'b0)    begin n_bad++; $display("FAIL reset_knn_clr: got %b want 0", bus.knn_clr); end
        n_cmp++; if (bus.out_vld !== 1'b0)    begin n_bad++; $display("FAIL reset_out_vld: got %b want 0", bus.out_vld); end
        n_cmp++; if (bus.out_res !== 2'd0)    begin n_bad++; $display("FAIL reset_out_res: got %0d want 0", bus.out_res); end
        n_cmp++; if (bus.out_err !== 1'b0)    begin n_bad++; $display("FAIL reset_out_err: got %b want 0", bus.out_err); end
        n_cmp++; if (bus.label !== 2'd0)      begin n_bad++; $display("FAIL reset_label: got %0d want 0", bus.label); end
        n_cmp++; if (bus.index !== 8'd0)      begin n_bad++; $display("FAIL reset_index: got %0d want 0", bus.index); end
        n_cmp++; if (bus.train_data !== '0)   begin n_bad++; $display("FAIL reset_train_data: got %h want 0", bus.train_data); end
        n_cmp++; if (bus.test_data !== '0)    begin n_bad++; $display("FAIL reset_test_data: got %h want 0", bus.test_data); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.test_rdy !== 1'b1)   begin n_bad++; $display("FAIL release_test_rdy: got %b want 1", bus.test_rdy); end
        for (int a = 0; a < 256; a++) mem_write(8'(a), $urandom, 2'($urandom));
    endtask

    task automatic test_basic();
        logic [31:0] vec;
        vec = 32'h10203040;
        mem_write(8'd0, $urandom, 2'd1);
        mem_write(8'd1, $urandom, 2'd2);
        mem_write(8'd2, $urandom, 2'd1);
        mem_write(8'd3, $urandom, 2'd3);
        run_txn(vec, 4, 10, 2'd2, 3, -1, 8'd0, 32'd0, 2'd0);
        n_cmp++; if (acc_rdy !== 1'b1) begin n_bad++; $display("FAIL basic_accept_rdy: got %b want 1", acc_rdy); end
        n_cmp++; if (out_off != exp_out_off(4, 10)) begin n_bad++; $display("FAIL basic_out_cycle: got T+%0d want T+%0d", out_off, exp_out_off(4, 10)); end
        for (int o = 1; o < out_off; o++) begin
            n_cmp++; if (obs_lbl[o] !== exp_lbl(o, 4)) begin n_bad++; $display("FAIL basic_label[T+%0d]: got %0d want %0d", o, obs_lbl[o], exp_lbl(o, 4)); end
            n_cmp++; if (obs_idx[o] !== exp_idx(o, 4)) begin n_bad++; $display("FAIL basic_index[T+%0d]: got %0d want %0d", o, obs_idx[o], exp_idx(o, 4)); end
            n_cmp++; if (obs_dat[o] !== exp_dat(o, 4)) begin n_bad++; $display("FAIL basic_train_data[T+%0d]: got %h want %h", o, obs_dat[o], exp_dat(o, 4)); end
            n_cmp++; if (obs_clr[o] !== (o == 1))      begin n_bad++; $display("FAIL basic_knn_clr[T+%0d]: got %b want %b", o, obs_clr[o], (o == 1)); end
            n_cmp++; if (obs_rdy[o] !== 1'b0)          begin n_bad++; $display("FAIL basic_test_rdy[T+%0d]: got %b want 0", o, obs_rdy[o]); end
            n_cmp++; if (obs_tdat[o] !== vec)          begin n_bad++; $display("FAIL basic_test_data[T+%0d]: got %h want %h", o, obs_tdat[o], vec); end
        end
        n_cmp++; if (got_res !== 2'd2)   begin n_bad++; $display("FAIL basic_out_res: got %0d want 2", got_res); end
        n_cmp++; if (got_err !== 1'b0)   begin n_bad++; $display("FAIL basic_out_err: got %b want 0", got_err); end
        n_cmp++; if (hold_bad != 0)      begin n_bad++; $display("FAIL basic_out_hold: got %0d unstable cycles want 0", hold_bad); end
        n_cmp++; if (vld_after !== 1'b0) begin n_bad++; $display("FAIL basic_vld_after: got %b want 0", vld_after); end
        n_cmp++; if (rdy_after !== 1'b1) begin n_bad++; $display("FAIL basic_rdy_after: got %b want 1", rdy_after); end
    endtask

    task automatic test_zero_count();
        run_txn($urandom, 0, -1, 2'd0, 1, -1, 8'd0, 32'd0, 2'd0);
        n_cmp++; if (out_off != 2)       begin n_bad++; $display("FAIL zero_out_cycle: got T+%0d want T+2", out_off); end
        n_cmp++; if (obs_clr[1] !== 1'b1) begin n_bad++; $display("FAIL zero_knn_clr: got %b want 1", obs_clr[1]); end
        n_cmp++; if (obs_lbl[1] !== 2'd0) begin n_bad++; $display("FAIL zero_label: got %0d want 0", obs_lbl[1]); end
        n_cmp++; if (got_res !== 2'd0)   begin n_bad++; $display("FAIL zero_out_res: got %0d want 0", got_res); end
        n_cmp++; if (got_err !== 1'b1)   begin n_bad++; $display("FAIL zero_out_err: got %b want 1", got_err); end
        n_cmp++; if (rdy_after !== 1'b1) begin n_bad++; $display("FAIL zero_rdy_after: got %b want 1", rdy_after); end
    endtask

    task automatic test_timeout();
        run_txn($urandom, 3, -1, 2'd0, 0, -1, 8'd0, 32'd0, 2'd0);
        n_cmp++; if (out_off - 5 != DRAIN_MAX) begin n_bad++; $display("FAIL timeout_drain_cycles: got %0d want %0d", out_off - 5, DRAIN_MAX); end
        n_cmp++; if (got_res !== 2'd0)   begin n_bad++; $display("FAIL timeout_out_res: got %0d want 0", got_res); end
        n_cmp++; if (got_err !== 1'b1)   begin n_bad++; $display("FAIL timeout_out_err: got %b want 1", got_err); end
        n_cmp++; if (vld_after !== 1'b0) begin n_bad++; $display("FAIL timeout_first_cycle_xfer: got out_vld %b want 0", vld_after); end
        run_txn($urandom, 2, DRAIN_MAX - 1, 2'd3, 0, -1, 8'd0, 32'd0, 2'd0);
        n_cmp++; if (out_off != exp_out_off(2, DRAIN_MAX - 1)) begin n_bad++; $display("FAIL lastcycle_out_cycle: got T+%0d want T+%0d", out_off, exp_out_off(2, DRAIN_MAX - 1)); end
        n_cmp++; if (got_res !== 2'd3)   begin n_bad++; $display("FAIL lastcycle_out_res: got %0d want 3", got_res); end
        n_cmp++; if (got_err !== 1'b0)   begin n_bad++; $display("FAIL lastcycle_out_err: got %b want 0", got_err); end
        run_txn($urandom, 1, 0, 2'd1, 0, -1, 8'd0, 32'd0, 2'd0);
        n_cmp++; if (out_off != 4)       begin n_bad++; $display("FAIL firstcycle_out_cycle: got T+%0d want T+4", out_off); end
        n_cmp++; if (got_res !== 2'd1)   begin n_bad++; $display("FAIL firstcycle_out_res: got %0d want 1", got_res); end
    endtask

    task automatic test_write_protect();
        logic [31:0] old1, new0;
        logic [1:0]  lbl1;
        old1 = ref_data[1];
        lbl1 = ref_label[1];
        run_txn($urandom, 4, 2, 2'd1, 0, 3, 8'd1, ~old1, lbl1 + 2'd1);
        new0 = $urandom;
        run_txn($urandom, 4, 2, 2'd1, 0, 0, 8'd0, new0, 2'd2);
        n_cmp++; if (obs_dat[2] !== new0) begin n_bad++; $display("FAIL wr_same_cycle_data: got %h want %h", obs_dat[2], new0); end
        n_cmp++; if (obs_lbl[2] !== 2'd2) begin n_bad++; $display("FAIL wr_same_cycle_label: got %0d want 2", obs_lbl[2]); end
        n_cmp++; if (obs_dat[3] !== old1) begin n_bad++; $display("FAIL wr_stream_ignored_data: got %h want %h", obs_dat[3], old1); end
        n_cmp++; if (obs_lbl[3] !== lbl1) begin n_bad++; $display("FAIL wr_stream_ignored_label: got %0d want %0d", obs_lbl[3], lbl1); end
    endtask

    task automatic test_reset_mid_stream();
        int seen_vld;
        bus.test_vld = 1'b1; bus.test_in = $urandom; bus.num_train = 8'd8;
        @(negedge clk);
        bus.test_vld = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.index !== 8'd2) begin n_bad++; $display("FAIL midrst_precondition_index: got %0d want 2", bus.index); end
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.label !== 2'd0)    begin n_bad++; $display("FAIL midrst_label: got %0d want 0", bus.label); end
        n_cmp++; if (bus.index !== 8'd0)    begin n_bad++; $display("FAIL midrst_index: got %0d want 0", bus.index); end
        n_cmp++; if (bus.train_data !== '0) begin n_bad++; $display("FAIL midrst_train_data: got %h want 0", bus.train_data); end
        n_cmp++; if (bus.test_data !== '0)  begin n_bad++; $display("FAIL midrst_test_data: got %h want 0", bus.test_data); end
        n_cmp++; if (bus.test_rdy !== 1'b0) begin n_bad++; $display("FAIL midrst_test_rdy: got %b want 0", bus.test_rdy); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.test_rdy !== 1'b1) begin n_bad++; $display("FAIL midrst_release_rdy: got %b want 1", bus.test_rdy); end
        seen_vld = 0;
        repeat (DRAIN_MAX + 12) begin
            @(negedge clk);
            if (bus.out_vld !== 1'b0) seen_vld++;
        end
        n_cmp++; if (seen_vld != 0) begin n_bad++; $display("FAIL midrst_no_out_vld: got %0d cycles want 0", seen_vld); end
        run_txn($urandom, 5, 3, 2'd1, 0, -1, 8'd0, 32'd0, 2'd0);
        n_cmp++; if (obs_idx[2] !== 8'd0)         begin n_bad++; $display("FAIL midrst_restart_index: got %0d want 0", obs_idx[2]); end
        n_cmp++; if (obs_dat[2] !== ref_data[0])  begin n_bad++; $display("FAIL midrst_restart_data: got %h want %h", obs_dat[2], ref_data[0]); end
        n_cmp++; if (got_res !== 2'd1)            begin n_bad++; $display("FAIL midrst_restart_res: got %0d want 1", got_res); end
    endtask

    task automatic test_random();
        int cnt, res_at, rdy_wait, wr_off, xo;
        logic [1:0]  res, xres;
        logic        xerr;
        logic [31:0] vec;
        for (int i = 0; i < 24; i++) begin
            cnt      = (i == 0) ? 255 : $urandom_range(0, 20);
            res_at   = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, DRAIN_MAX + 4);
            res      = 2'($urandom);
            rdy_wait = $urandom_range(0, 3);
            wr_off   = ($urandom_range(0, 1) == 0) ? 0 : -1;
            vec      = $urandom;
            run_txn(vec, cnt, res_at, res, rdy_wait, wr_off, 8'($urandom_range(0, 7)), $urandom, 2'($urandom));
            xo   = exp_out_off(cnt, res_at);
            xerr = (xo != cnt + 3 + res_at) || (cnt == 0);
            xres = xerr ? 2'd0 : res;
            n_cmp++; if (out_off != xo) begin n_bad++; $display("FAIL rand%0d_out_cycle: got T+%0d want T+%0d", i, out_off, xo); end
            for (int o = 1; o < out_off; o++) begin
                n_cmp++; if (obs_lbl[o] !== exp_lbl(o, cnt)) begin n_bad++; $display("FAIL rand%0d_label[T+%0d]: got %0d want %0d", i, o, obs_lbl[o], exp_lbl(o, cnt)); end
                n_cmp++; if (obs_idx[o] !== exp_idx(o, cnt)) begin n_bad++; $display("FAIL rand%0d_index[T+%0d]: got %0d want %0d", i, o, obs_idx[o], exp_idx(o, cnt)); end
                n_cmp++; if (obs_dat[o] !== exp_dat(o, cnt)) begin n_bad++; $display("FAIL rand%0d_train_data[T+%0d]: got %h want %h", i, o, obs_dat[o], exp_dat(o, cnt)); end
                n_cmp++; if (obs_clr[o] !== (o == 1))        begin n_bad++; $display("FAIL rand%0d_knn_clr[T+%0d]: got %b want %b", i, o, obs_clr[o], (o == 1)); end
                n_cmp++; if (obs_tdat[o] !== vec)            begin n_bad++; $display("FAIL rand%0d_test_data[T+%0d]: got %h want %h", i, o, obs_tdat[o], vec); end
                n_cmp++; if (obs_rdy[o] !== 1'b0)            begin n_bad++; $display("FAIL rand%0d_test_rdy[T+%0d]: got %b want 0", i, o, obs_rdy[o]); end
            end
            n_cmp++; if (got_res !== xres)   begin n_bad++; $display("FAIL rand%0d_out_res: got %0d want %0d", i, got_res, xres); end
            n_cmp++; if (got_err !== xerr)   begin n_bad++; $display("FAIL rand%0d_out_err: got %b want %b", i, got_err, xerr); end
            n_cmp++; if (hold_bad != 0)      begin n_bad++; $display("FAIL rand%0d_out_hold: got %0d unstable cycles want 0", i, hold_bad); end
            n_cmp++; if (vld_after !== 1'b0) begin n_bad++; $display("FAIL rand%0d_vld_after: got %b want 0", i, vld_after); end
            n_cmp++; if (rdy_after !== 1'b1) begin n_bad++; $display("FAIL rand%0d_rdy_after: got %b want 1", i, rdy_after); end
        end
    endtask

    initial begin
        rst = 1'b0;
        drive_idle();
        test_reset();
        test_basic();
        test_zero_count();
        test_timeout();
        test_write_protect();
        test_reset_mid_stream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule

// File: doc/knn_feeder.md
KNN_FEEDER -- requirements
Module: knn_feeder

Interface
REQ-001 Parameter DRAIN_MAX, default 32: maximum drain cycles to wait for a kNN result before timing out.
REQ-002 clk  in  1  single clock; all state is updated on its rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 wr_en/wr_addr/wr_data/wr_label  in  1/8/32/2  training-memory write port; label 0 is reserved and means bubble.
REQ-005 num_train  in  8  number of training samples to stream, 0..255.
REQ-006 test_vld/test_rdy/test_in  in/out/in  1/1/32  test-vector handshake.
REQ-007 train_data/test_data/label/index  out  32/32/2/8  sample stream to the kNN pipeline.
REQ-008 knn_clr  out  1  one-cycle synchronous clear pulse to the kNN pipeline.
REQ-009 knn_res/knn_res_vld  in  2/1  result returned by the kNN pipeline.
REQ-010 out_vld/out_rdy/out_res/out_err  out/in/out/out  1/1/2/1  classification result handshake.

Function
REQ-011 Internal memory SHALL be 256 x 34 bits ({label, data}), written synchronously, read asynchronously.
REQ-012 A write SHALL be accepted only in IDLE; wr_en in any other state SHALL be ignored.
REQ-013 FSM states SHALL be IDLE, CLEAR, STREAM, DRAIN and OUT.
REQ-014 IDLE: test_rdy=1; on test_vld&test_rdy latch test_in into test_data and num_train into a count register, then go to CLEAR.
REQ-015 A write and a test acceptance in the same cycle SHALL both take effect, and the streamed data SHALL include that write.
REQ-016 CLEAR: knn_clr=1 for exactly one cycle; next state is STREAM, or OUT with out_res=0 and out_err=1 if the latched count is 0.
REQ-017 STREAM: for k=0..count-1 on consecutive cycles, registered outputs SHALL be train_data=mem[k].data, label=mem[k].label, index=k; after the last sample go to DRAIN.
REQ-018 Latency: test accepted in cycle T -> knn_clr in T+1 -> first sample on the outputs in T+2 -> last sample in T+1+count.
REQ-019 Outside STREAM, label=0, train_data=0 and index=0.
REQ-020 test_data SHALL hold the latched vector from acceptance until return to IDLE.
REQ-021 DRAIN: 8-bit counter from 0; on knn_res_vld capture knn_res into out_res, set out_err=0 and go to OUT.
REQ-022 DRAIN: if the counter reaches DRAIN_MAX-1 without knn_res_vld, go to OUT with out_res=0 and out_err=1.
REQ-023 knn_res_vld SHALL be ignored outside DRAIN.
REQ-024 OUT: out_vld=1 with out_res and out_err stable until out_rdy; on out_vld&out_rdy return to IDLE.
REQ-025 With out_rdy held high, the result is transferred on the first OUT cycle.
REQ-026 A new test SHALL NOT be accepted until the OUT transfer completes; test_rdy=0 in all non-IDLE states.

Reset
REQ-027 On rst low: state=IDLE; test_rdy=0 while asserted.
REQ-028 On rst low: knn_clr, out_vld, out_res, out_err, train_data, test_data, label, index and all counters SHALL be 0.
REQ-029 Memory contents SHALL NOT be reset; the bench writes before use.
REQ-030 Reset mid-STREAM or mid-DRAIN SHALL abort immediately with no out_vld; test_rdy=1 on the first cycle after release.

Structure
REQ-031 The state enum, NUM_BIT, label width 2, index width 8 and the BUBBLE=2'd0 constant SHALL live in the shared package.
REQ-032 The memory SHALL be one sub-module, knn_train_mem, with one write port and one asynchronous read port.
REQ-033 FSM and counters SHALL be in knn_feeder.

Verification
REQ-034 Write 4 samples (labels 1,2,1,3); num_train=4; send test 32'h10203040 -> knn_clr at T+1; index 0..3 with labels 1,2,1,3 on T+2..T+5; label=0 from T+6.
REQ-035 In DRAIN, model returns knn_res=2 with knn_res_vld after 10 cycles -> out_vld=1, out_res=2, out_err=0, held while out_rdy=0 for 3 cycles; test_rdy=1 after the transfer.
REQ-036 num_train=0 -> no label≠0 output, OUT with out_res=0 and out_err=1 at T+2.
REQ-037 knn_res_vld never asserted -> exactly 32 DRAIN cycles, then out_err=1 and out_res=0.
REQ-038 wr_en during STREAM to address 1 with new data -> memory unchanged on the next run; wr_en and test_vld together in IDLE to address 0 -> new data streamed at index 0.
REQ-039 rst pulsed low during STREAM at k=2 -> all outputs 0 asynchronously, no out_vld, next test streams from index 0.
